// File: rtl/utopia_rx_if.sv
// Utopia Level-1 Rx pin bundle plus the per-byte tagging
// that the scheduler hands to the switch core.
interface utopia_rx_if #(
  parameter int NumRx = 4
) ();
  localparam int PtrW = (NumRx > 1) ? $clog2(NumRx) : 1;

  logic [NumRx-1:0] rx_clav;
  logic [NumRx-1:0] rx_soc;
  logic [NumRx-1:0] rx_en;
  logic [PtrW-1:0]  sel_port;
  logic             sel_valid;
  logic             byte_valid;
  logic [5:0]       byte_idx;
  logic             cell_done;
  logic             soc_err;

  modport master (
    input  rx_clav,
    input  rx_soc,
    output rx_en,
    output sel_port,
    output sel_valid,
    output byte_valid,
    output byte_idx,
    output cell_done,
    output soc_err
  );

  modport slave (
    output rx_clav,
    output rx_soc,
    input  rx_en,
    input  sel_port,
    input  sel_valid,
    input  byte_valid,
    input  byte_idx,
    input  cell_done,
    input  soc_err
  );
endinterface

// File: rtl/utopia_rx_sched.sv
// Round-robin cell scheduler for the Utopia Rx ports:
// grants one port per cell, tags bytes, checks soc.
module utopia_rx_sched #(
  parameter int NumRx     = 4,
  parameter int CellBytes = 53
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NumRx-1:0] port_mask,
  input  logic             core_ready,
  utopia_rx_if.master      bus
);
  localparam int PtrW = (NumRx > 1) ? $clog2(NumRx) : 1;
  localparam logic [5:0] LastIdx = 6'(CellBytes - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } state_e;

  state_e           state_q;
  logic [PtrW-1:0]  rr_q;
  logic [PtrW-1:0]  sel_q;
  logic [NumRx-1:0] en_q;
  logic [5:0]       cnt_q;
  logic [5:0]       idx_q;
  logic             bv_q;
  logic             cd_q;

  logic [NumRx-1:0] req;
  logic [PtrW-1:0]  win_d;
  logic [PtrW-1:0]  ptr;
  logic             hit_d;
  logic             abort;

  function automatic logic [PtrW-1:0] inc(
    input logic [PtrW-1:0] p
  );
    return (int'(p) == NumRx - 1) ? '0 : p + 1'b1;
  endfunction

  assign req = bus.rx_clav & port_mask;

  always_comb begin
    win_d = rr_q;
    hit_d = 1'b0;
    ptr   = rr_q;
    for (int i = 0; i < NumRx; i++) begin
      if (!hit_d && req[ptr]) begin
        win_d = ptr;
        hit_d = 1'b1;
      end
      ptr = inc(ptr);
    end
  end

  // Byte 0 without soc kills the cell before byte 1 reaches the core
  assign abort = bv_q && (idx_q == '0) && !bus.rx_soc[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      en_q    <= '1;
      cnt_q   <= '0;
      idx_q   <= '0;
      bv_q    <= 1'b0;
      cd_q    <= 1'b0;
    end else begin
      bv_q  <= (state_q == XFER) && !abort;
      idx_q <= cnt_q;
      cd_q  <= (state_q == XFER) && !abort &&
               (cnt_q == LastIdx);
      unique case (state_q)
        IDLE: begin
          en_q <= '1;
          if (core_ready && hit_d) begin
            sel_q       <= win_d;
            en_q[win_d] <= 1'b0;
            cnt_q       <= '0;
            state_q     <= XFER;
          end
        end
        XFER: begin
          if (abort) begin
            en_q    <= '1;
            cnt_q   <= '0;
            rr_q    <= inc(sel_q);
            state_q <= IDLE;
          end else if (cnt_q == LastIdx) begin
            en_q    <= '1;
            cnt_q   <= '0;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DRAIN: begin
          en_q    <= '1;
          rr_q    <= inc(sel_q);
          state_q <= IDLE;
        end
        default: begin
          en_q    <= '1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_en      = en_q;
  assign bus.sel_port   = sel_q;
  assign bus.sel_valid  = (state_q != IDLE);
  assign bus.byte_valid = bv_q && !abort;
  assign bus.byte_idx   = idx_q;
  assign bus.cell_done  = cd_q;
  assign bus.soc_err    = abort;
endmodule
